// File: rtl/fifo_ser_pkg.sv
// Shared constants and state encoding for the FIFO serial drain stage.
// The parity slot is only used when FIFO_SERIAL_TX_PARITY_EN is defined.
package fifo_ser_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_e;

    // Counter width that stays at least one bit for a divide-by-one baud rate.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_serial_tx_baud_tick_gen.sv
// Bit-period divider: tick marks the last clk of every CLKS_PER_BIT-cycle slot.
// clear holds the count at zero so the first slot after it is full length.
module baud_tick_gen
    import fifo_ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = cnt_w(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains one FIFO word per frame onto an async serial line (start, data LSB first, stop).
// Define FIFO_SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_serial_tx
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              pop_o,
    output logic              line_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              line_q, line_d;
    logic              pop_q, pop_d;
    logic              busy_q, busy_d;
    logic              tick;
    logic              baud_clear;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // The divider only runs while a bit slot is on the line.
    assign baud_clear = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable_i && !fifo_empty_i) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d   = fifo_data_i;
                bit_cnt_d = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                parity_d  = ^fifo_data_i;
`endif
                state_d   = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        pop_d  = (state_d == POP);
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   line_d = START_BIT;
            DATA:    line_d = shreg_d[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY:  line_d = parity_d;
`endif
            default: line_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            line_q    <= LINE_IDLE;
            pop_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            line_q    <= line_d;
            pop_q     <= pop_d;
            busy_q    <= busy_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign pop_o        = pop_q;
    assign line_o       = line_q;
    assign busy_o       = busy_q;
    assign frame_done_o = (state_q == STOP) && tick;

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Downstream drain stage for the 8-bit FIFO.
- Pops one byte at a time through the FIFO's pop/data-out interface and transmits it on a single line as an asynchronous serial frame: start bit, DATA_W data bits LSB first, optional parity bit, one stop bit.
- Sits between the FIFO and the chip-level serial pin.
- Paces FIFO reads so the FIFO never underflows.

Parameters:
- DATA_W, 8, width of each FIFO word and data bits per frame.
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal range ≥1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable_i  input  1  permits starting a new frame; does not abort a frame in progress.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_data_i  input  DATA_W  FIFO data-out; valid the cycle after pop_o was high.
- pop_o  input→output  1  registered one-cycle pop request to the FIFO.
- line_o  output  1  serial line; idles high.
- busy_o  output  1  high whenever the state is not IDLE.
- frame_done_o  output  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Reset (sync, active-high; applies mid-frame too):
  - On the next edge: state=IDLE, line_o=1, pop_o=0, busy_o=0, frame_done_o=0.
  - Shift register and counters are cleared.
  - A frame in flight is dropped, not resumed.
- FSM states: IDLE, POP, LOAD, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - line_o=1.
  - If enable_i=1 and fifo_empty_i=0 → POP.
  - fifo_empty_i is sampled only in IDLE.
- POP:
  - pop_o=1 for exactly this one cycle.
  - → LOAD unconditionally.
- LOAD:
  - Capture fifo_data_i into the shift register.
  - Clear the baud counter.
  - → START.
- START: line_o=0 for CLKS_PER_BIT cycles → DATA.
- DATA:
  - line_o = shreg[0].
  - On each baud tick, shift right; bit counter increments.
  - After DATA_W bits → PARITY (if enabled) or STOP.
- STOP:
  - line_o=1 for CLKS_PER_BIT cycles.
  - frame_done_o is high on the last of those cycles.
  - → IDLE.
- Frame spacing: at least one IDLE cycle between frames, so a back-to-back pop comes ≥3 cycles after the previous pop. This gives the FIFO's registered empty flag time to settle.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide (min 1). A tick occurs when count==CLKS_PER_BIT-1, then wraps to 0.
  - Bit counter is $clog2(DATA_W+1) bits wide.
  - CLKS_PER_BIT=1: every cycle is a tick.
- Latency:
  - IDLE decision cycle to first start-bit cycle = 3 clk (POP, LOAD, then START).
  - Line frame length = (DATA_W+2)*CLKS_PER_BIT cycles, or (DATA_W+3)*CLKS_PER_BIT with parity.
- enable_i falling mid-frame: the frame completes normally; no further pops.
- fifo_empty_i rising during a frame: ignored until IDLE.
- pop_o is never asserted outside POP and never while reset is high.

Optional Feature:
- Macro FIFO_SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; line_o = even parity (XOR of the DATA_W bits), held CLKS_PER_BIT cycles.
  - Parity is computed at LOAD from fifo_data_i.
- Undefined:
  - No PARITY state, no parity register; DATA → STOP directly.
  - Frame length is (DATA_W+2)*CLKS_PER_BIT.

Decomposition:
- Shared package fifo_ser_pkg holds:
  - State encoding localparams/enum: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
  - Default DATA_W and CLKS_PER_BIT constants.
  - LINE_IDLE=1'b1 and START_BIT=1'b0.
- One natural sub-module, baud_tick_gen:
  - Parameter CLKS_PER_BIT; inputs clk, reset, clear; output tick.
  - Instantiated once in fifo_serial_tx.

Test Plan:
1. CLKS_PER_BIT=4, FIFO holds 0xA5, enable_i=1 → pop_o high exactly 1 cycle; line_o 4-cycle slots read 0,1,0,1,0,0,1,0,1,1; frame_done_o pulses once at slot-10 end; busy_o then drops.
2. FIFO loaded 0x01,0xFF,0x00 back-to-back → three pops, each ≥3 cycles apart with ≥1 IDLE cycle between frames; bytes emitted in order; no pop after empty asserts.
3. fifo_empty_i=1, enable_i toggling for 50 cycles → pop_o never asserts; line_o stays 1; busy_o=0.
4. reset asserted in DATA bit 3 of 0x3C → next cycle line_o=1, busy_o=0, pop_o=0; after release with FIFO empty, no further line activity.
5. enable_i dropped in START of 0x81 → full frame 0,1,0,0,0,0,0,0,1,1 completes; no second pop while enable_i=0.
6. FIFO_SERIAL_TX_PARITY_EN defined, bytes 0xA5 and 0x07 → parity slot 0 then 1; 11 slots per frame; CLKS_PER_BIT=1 variant gives a 1-cycle-per-bit line.
